// File: rtl/dmem_unit.sv
// Data-memory stage: word-organised RAM with big-endian byte-lane stores, registered
// extending loads, misalignment detection and a debug read/dump port (dump: DMEM_DUMP_EN).
module dmem_unit #(
  parameter int NB_WIDTH = 32,
  parameter int NB_ADDR  = 9
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic [NB_WIDTH-1:0]                    i_mem_addr,
  input  logic [NB_WIDTH-1:0]                    i_mem_data,
  input  logic                                   i_mem_read_CU,
  input  logic                                   i_mem_write_CU,
  input  logic [2:0]                             i_BHW_CU,
  output logic [NB_WIDTH-1:0]                    o_read_data,
  output logic                                   o_misaligned,
  input  logic                                   i_dbg_rd,
  input  logic [NB_ADDR-$clog2(NB_WIDTH/8)-1:0]  i_dbg_addr,
  input  logic                                   i_dbg_dump_start,
  input  logic                                   i_dbg_ready,
  output logic [NB_WIDTH-1:0]                    o_dbg_data,
  output logic                                   o_dbg_valid,
  output logic                                   o_dbg_last,
  output logic                                   o_dbg_busy
);

  localparam int NB_LANE  = NB_WIDTH / 8;
  localparam int NB_OFF   = $clog2(NB_LANE);
  localparam int NB_WADDR = NB_ADDR - NB_OFF;
  localparam int DEPTH    = (2 ** NB_ADDR) / NB_LANE;

  logic [NB_WIDTH-1:0] mem_q [DEPTH];

  logic [NB_OFF-1:0]   off;
  logic [NB_WADDR-1:0] widx;
  logic                unused_addr;

  assign off         = i_mem_addr[NB_OFF-1:0];
  assign widx        = i_mem_addr[NB_ADDR-1:NB_OFF];
  assign unused_addr = ^i_mem_addr[NB_WIDTH-1:NB_ADDR];

  logic bad_align;
  logic fault;

  always_comb begin
    bad_align = 1'b0;
    case (i_BHW_CU[1:0])
      2'b01:   bad_align = i_mem_addr[0];
      2'b11:   bad_align = |off;
      default: bad_align = 1'b0;
    endcase
    fault = (i_mem_read_CU | i_mem_write_CU) & bad_align;
  end

  // Store path: lane k holds byte offset k (big-endian), so lane k is word bits [W-1-8k -: 8].
  logic [NB_LANE-1:0]  lane_we;
  logic [NB_WIDTH-1:0] wword;

  always_comb begin
    lane_we = '0;
    wword   = '0;
    for (int unsigned k = 0; k < NB_LANE; k++) begin
      case (i_BHW_CU[1:0])
        2'b00: begin
          wword[NB_WIDTH-1-8*k -: 8] = i_mem_data[7:0];
          lane_we[k]                 = (NB_OFF'(k) == off);
        end
        2'b01: begin
          wword[NB_WIDTH-1-8*k -: 8] = k[0] ? i_mem_data[7:0] : i_mem_data[15:8];
          lane_we[k]                 = ((NB_OFF'(k) | NB_OFF'(1)) == (off | NB_OFF'(1)));
        end
        2'b11: begin
          wword[NB_WIDTH-1-8*k -: 8] = i_mem_data[NB_WIDTH-1-8*k -: 8];
          lane_we[k]                 = 1'b1;
        end
        default: ;
      endcase
    end
    if (!i_mem_write_CU || fault) lane_we = '0;
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < NB_LANE; k++) begin
      if (lane_we[k]) mem_q[widx][NB_WIDTH-1-8*k -: 8] <= wword[NB_WIDTH-1-8*k -: 8];
    end
  end

  // Load path reads the pre-store word, giving read-before-write on a simultaneous access.
  logic [NB_WIDTH-1:0] rword;
  logic [7:0]          b_sel;
  logic [7:0]          h_lo;
  logic [NB_WIDTH-1:0] read_data_d, read_data_q;
  logic                mis_q;

  assign rword = mem_q[widx];

  always_comb begin
    b_sel = '0;
    h_lo  = '0;
    for (int unsigned k = 0; k < NB_LANE; k++) begin
      if (NB_OFF'(k) == off)                h_lo = h_lo;
      if (NB_OFF'(k) == off)                b_sel = rword[NB_WIDTH-1-8*k -: 8];
      if (NB_OFF'(k) == (off | NB_OFF'(1))) h_lo  = rword[NB_WIDTH-1-8*k -: 8];
    end
  end

  always_comb begin
    read_data_d = '0;
    if (i_mem_read_CU && !fault) begin
      case (i_BHW_CU)
        3'b000:         read_data_d = {{(NB_WIDTH-8){b_sel[7]}}, b_sel};
        3'b100:         read_data_d = {{(NB_WIDTH-8){1'b0}}, b_sel};
        3'b001:         read_data_d = {{(NB_WIDTH-16){b_sel[7]}}, b_sel, h_lo};
        3'b101:         read_data_d = {{(NB_WIDTH-16){1'b0}}, b_sel, h_lo};
        3'b011, 3'b111: read_data_d = rword;
        default:        read_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      read_data_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      mis_q       <= fault;
    end
  end

  assign o_read_data  = read_data_q;
  assign o_misaligned = mis_q;

  // Debug port: dedicated read port, output word is a registered snapshot.
  logic [NB_WIDTH-1:0] dbg_data_d, dbg_data_q;
  logic                dbg_valid_d, dbg_valid_q;
  logic                dbg_last_d, dbg_last_q;

`ifdef DMEM_DUMP_EN
  typedef enum logic [1:0] {IDLE, DUMP, HOLD} dump_state_e;

  localparam logic [NB_WADDR-1:0] LAST_PTR = NB_WADDR'(DEPTH - 1);

  dump_state_e         state_d, state_q;
  logic [NB_WADDR-1:0] ptr_d, ptr_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dbg_data_d  = dbg_data_q;
    dbg_valid_d = dbg_valid_q;
    dbg_last_d  = dbg_last_q;
    case (state_q)
      IDLE: begin
        // A presented single-read word blocks new requests until it is accepted.
        if (dbg_valid_q) begin
          if (i_dbg_ready) begin
            dbg_valid_d = 1'b0;
            dbg_last_d  = 1'b0;
          end
        end else if (i_dbg_dump_start) begin
          state_d = DUMP;
          ptr_d   = '0;
        end else if (i_dbg_rd) begin
          dbg_data_d  = mem_q[i_dbg_addr];
          dbg_valid_d = 1'b1;
          dbg_last_d  = 1'b1;
        end
      end
      DUMP: begin
        dbg_data_d  = mem_q[ptr_q];
        dbg_valid_d = 1'b1;
        dbg_last_d  = (ptr_q == LAST_PTR);
        state_d     = HOLD;
      end
      HOLD: begin
        if (i_dbg_ready) begin
          dbg_valid_d = 1'b0;
          dbg_last_d  = 1'b0;
          if (ptr_q == LAST_PTR) begin
            state_d = IDLE;
          end else begin
            ptr_d   = ptr_q + NB_WADDR'(1);
            state_d = DUMP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_dbg_busy = (state_q != IDLE);
`else
  logic unused_dump_start;

  assign unused_dump_start = i_dbg_dump_start;

  always_comb begin
    dbg_data_d  = dbg_data_q;
    dbg_valid_d = dbg_valid_q;
    dbg_last_d  = dbg_last_q;
    if (dbg_valid_q) begin
      if (i_dbg_ready) begin
        dbg_valid_d = 1'b0;
        dbg_last_d  = 1'b0;
      end
    end else if (i_dbg_rd) begin
      dbg_data_d  = mem_q[i_dbg_addr];
      dbg_valid_d = 1'b1;
      dbg_last_d  = 1'b1;
    end
  end

  assign o_dbg_busy = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
      dbg_last_q  <= 1'b0;
    end else begin
      dbg_data_q  <= dbg_data_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_last_q  <= dbg_last_d;
    end
  end

  assign o_dbg_data  = dbg_data_q;
  assign o_dbg_valid = dbg_valid_q;
  assign o_dbg_last  = dbg_last_q;

endmodule
